// File: rtl/k054539_pkg.sv
// Shared constants and types for the k054539 CPU front end.
// Bus address map constants, timing parameter defaults and the 10-bit address type.
package k054539_pkg;

  typedef logic [9:0] bus_addr_t;

  localparam bus_addr_t KEYON     = 10'h214;
  localparam bus_addr_t KEYOFF    = 10'h215;
  localparam bus_addr_t STATUS    = 10'h22C;
  localparam bus_addr_t CTRL_LAST = 10'h22F;

  localparam int WAIT_CYCLES_DEF     = 4;
  localparam int CLKS_PER_SAMPLE_DEF = 384;
  localparam int DTCK_DIV_LOG2_DEF   = 3;

endpackage

// File: rtl/k054539_bus_sync.sv
// Two-flop synchroniser plus history flop and edge detect for one active-low bus strobe
// qualified by chip select; acc_o pulses once per strobe assertion.
module k054539_bus_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ncs_i,
  input  logic nstb_i,
  output logic act_o,
  output logic acc_o
);

  logic [1:0] ncs_q;
  logic [1:0] nstb_q;
  logic [1:0] vld_q;
  logic       act_s3_q;

  // The history flop reads "active" until the synchroniser holds real samples, so a
  // strobe already low when reset releases never counts as a fresh edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ncs_q    <= 2'b11;
      nstb_q   <= 2'b11;
      vld_q    <= 2'b00;
      act_s3_q <= 1'b1;
    end else begin
      ncs_q    <= {ncs_q[0], ncs_i};
      nstb_q   <= {nstb_q[0], nstb_i};
      vld_q    <= {vld_q[0], 1'b1};
      act_s3_q <= vld_q[1] ? act_o : 1'b1;
    end
  end

  assign act_o = !ncs_q[1] && !nstb_q[1];
  assign acc_o = act_o && !act_s3_q;

endmodule

// File: rtl/k054539.sv
// Konami 054539 CPU front end: bus sync, parameter RAM, control bank, key status, WAIT and DAC clocks.
// Optional K054539_READBACK_EN adds PIN_DB_OUT / PIN_DB_OE and the read data mux.
module k054539
  import k054539_pkg::*;
#(
  parameter int WAIT_CYCLES     = WAIT_CYCLES_DEF,
  parameter int CLKS_PER_SAMPLE = CLKS_PER_SAMPLE_DEF,
  parameter int DTCK_DIV_LOG2   = DTCK_DIV_LOG2_DEF
) (
  input  logic       NRES,
  input  logic       CLK,
  input  logic [7:0] PIN_AB,
  input  logic       PIN_AB09,
  input  logic [7:0] PIN_DB_IN,
  input  logic       NCS,
  input  logic       NRD,
  input  logic       NWR,
  output logic       PIN_WAIT,
  output logic       PIN_DTCK,
  output logic       PIN_WDCK
`ifdef K054539_READBACK_EN
  ,
  output logic [7:0] PIN_DB_OUT,
  output logic       PIN_DB_OE
`endif
);

  localparam int CNT_W  = $clog2(CLKS_PER_SAMPLE);
  localparam int WCNT_W = $clog2(WAIT_CYCLES + 1);

  logic              wr_act, wr_acc, rd_act, rd_acc;
  bus_addr_t         addr;
  logic              ctrl_hit;
  logic [7:0]        ram_q  [256];
  logic [7:0]        ctrl_q [48];
  logic [7:0]        status_q;
  logic              wait_n_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dtck_q, wdck_q;
  logic              unused_act;

  k054539_bus_sync u_wr_sync (
    .clk_i (CLK), .rst_ni (NRES), .ncs_i (NCS), .nstb_i (NWR),
    .act_o (wr_act), .acc_o (wr_acc)
  );

  k054539_bus_sync u_rd_sync (
    .clk_i (CLK), .rst_ni (NRES), .ncs_i (NCS), .nstb_i (NRD),
    .act_o (rd_act), .acc_o (rd_acc)
  );

  // AB08 is not brought out, so the decoded address always has bit 8 clear.
  assign addr     = {PIN_AB09, 1'b0, PIN_AB};
  assign ctrl_hit = PIN_AB09 && (PIN_AB <= CTRL_LAST[7:0]);

  always_ff @(posedge CLK) begin
    if (wr_acc && !PIN_AB09) ram_q[PIN_AB] <= PIN_DB_IN;
  end

  // Key-on/key-off act on the status bits and are not stored; status itself is read-only.
  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      status_q <= 8'h00;
      for (int i = 0; i < 48; i++) ctrl_q[i] <= 8'h00;
    end else if (wr_acc && ctrl_hit) begin
      if (addr == KEYON)       status_q <= status_q | PIN_DB_IN;
      else if (addr == KEYOFF) status_q <= status_q & ~PIN_DB_IN;
      else if (addr != STATUS) ctrl_q[PIN_AB[5:0]] <= PIN_DB_IN;
    end
  end

  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      wait_n_q <= 1'b1;
      wcnt_q   <= '0;
    end else if (wr_acc || rd_acc) begin
      wait_n_q <= 1'b0;
      wcnt_q   <= WCNT_W'(WAIT_CYCLES - 1);
    end else if (!wait_n_q) begin
      if (wcnt_q == '0) wait_n_q <= 1'b1;
      else              wcnt_q   <= wcnt_q - WCNT_W'(1);
    end
  end

  // DAC clocks are registered from the next count so they stay phase-aligned with cnt_q.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_W'(CLKS_PER_SAMPLE - 1)) cnt_d = '0;
  end

  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      cnt_q  <= '0;
      dtck_q <= 1'b0;
      wdck_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dtck_q <= cnt_d[DTCK_DIV_LOG2-1];
      wdck_q <= (cnt_d >= CNT_W'(CLKS_PER_SAMPLE / 2));
    end
  end

  assign PIN_WAIT = wait_n_q;
  assign PIN_DTCK = dtck_q;
  assign PIN_WDCK = wdck_q;

`ifdef K054539_READBACK_EN
  logic [7:0] rd_mux;
  logic [7:0] rdata_q;

  always_comb begin
    rd_mux = 8'h00;
    if (!PIN_AB09)            rd_mux = ram_q[PIN_AB];
    else if (addr == STATUS)  rd_mux = status_q;
    else if (ctrl_hit)        rd_mux = ctrl_q[PIN_AB[5:0]];
  end

  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES)       rdata_q <= 8'h00;
    else if (rd_acc) rdata_q <= rd_mux;
  end

  assign PIN_DB_OUT = rdata_q;
  assign PIN_DB_OE  = rd_act;
  assign unused_act = wr_act;
`else
  // Without readback the stores have no on-chip reader; keep them referenced.
  assign unused_act = wr_act ^ rd_act ^ (^ram_q[PIN_AB]) ^ (^ctrl_q[PIN_AB[5:0]]) ^ (^status_q);
`endif

endmodule

// File: tb/tb_k054539.sv
// Scoreboard bench for k054539: expected stores are queued as writes are driven and
// compared once the access's WAIT pulse has completed.
module tb_k054539;

  localparam int WAIT_CYCLES = 4;

  logic       CLK = 1'b0;
  logic       NRES = 1'b0;
  logic [7:0] PIN_AB = 8'h00;
  logic       PIN_AB09 = 1'b0;
  logic [7:0] PIN_DB_IN = 8'h00;
  logic       NCS = 1'b1;
  logic       NRD = 1'b1;
  logic       NWR = 1'b1;
  logic       PIN_WAIT, PIN_DTCK, PIN_WDCK;
`ifdef K054539_READBACK_EN
  logic [7:0] PIN_DB_OUT;
  logic       PIN_DB_OE;
`endif

  typedef struct {
    int         kind;   // 0 = RAM, 1 = control bank, 2 = status
    int         idx;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] m_status = 8'h00;

  k054539 dut (
    .NRES      (NRES),
    .CLK       (CLK),
    .PIN_AB    (PIN_AB),
    .PIN_AB09  (PIN_AB09),
    .PIN_DB_IN (PIN_DB_IN),
    .NCS       (NCS),
    .NRD       (NRD),
    .NWR       (NWR),
    .PIN_WAIT  (PIN_WAIT),
    .PIN_DTCK  (PIN_DTCK),
    .PIN_WDCK  (PIN_WDCK)
`ifdef K054539_READBACK_EN
    ,
    .PIN_DB_OUT(PIN_DB_OUT),
    .PIN_DB_OE (PIN_DB_OE)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] observe(input int kind, input int idx);
    logic [7:0] a;
    a = idx[7:0];
    case (kind)
      0:       return dut.ram_q[a];
      1:       return dut.ctrl_q[a[5:0]];
      default: return dut.status_q;
    endcase
  endfunction

  // One bus access: strobe held low for 'hold' clocks; counts WAIT pulses and low clocks.
  task automatic bus_access(input bit wr, input logic [9:0] a, input logic [7:0] d,
                            input int hold, output int pulses, output int width);
    bit prev;
    prev = 1'b1;
    pulses = 0;
    width = 0;
    @(negedge CLK);
    PIN_AB09 = a[9];
    PIN_AB = a[7:0];
    PIN_DB_IN = d;
    NCS = 1'b0;
    if (wr) NWR = 1'b0;
    else NRD = 1'b0;
    for (int i = 0; i < hold + WAIT_CYCLES + 4; i++) begin
      @(negedge CLK);
      if (!PIN_WAIT) begin
        width++;
        if (prev) pulses++;
      end
      prev = PIN_WAIT;
      if (i == hold - 1) begin
        NCS = 1'b1;
        NWR = 1'b1;
        NRD = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    NRES = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (PIN_WAIT !== 1'b1 || PIN_DTCK !== 1'b0 || PIN_WDCK !== 1'b0 || dut.status_q !== 8'h00) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL reset_hold: %0d bad cycles, required 0", bad); else n_pass++;
    n_checks++;
    if (PIN_WAIT !== 1'b1) $display("FAIL reset_wait: got %b, required 1", PIN_WAIT); else n_pass++;
    n_checks++;
    if (PIN_DTCK !== 1'b0) $display("FAIL reset_dtck: got %b, required 0", PIN_DTCK); else n_pass++;
    n_checks++;
    if (PIN_WDCK !== 1'b0) $display("FAIL reset_wdck: got %b, required 0", PIN_WDCK); else n_pass++;
    n_checks++;
    if (dut.status_q !== 8'h00) $display("FAIL reset_status: got %h, required 00", dut.status_q); else n_pass++;
    NRES = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_writes();
    logic [9:0] addrs[3];
    logic [7:0] datas[3];
    int p, w;
    exp_t e;
    addrs = '{10'h050, 10'h051, 10'h210};
    datas = '{8'h11, 8'h22, 8'h55};
    for (int k = 0; k < 3; k++) begin
      e.kind = addrs[k][9] ? 1 : 0;
      e.idx = int'(addrs[k][7:0]);
      e.val = datas[k];
      sb.push_back(e);
      bus_access(1'b1, addrs[k], datas[k], 7, p, w);
      n_checks++;
      if (p !== 1 || w !== WAIT_CYCLES)
        $display("FAIL write_wait[%0d]: pulses=%0d width=%0d, required 1 and %0d", k, p, w, WAIT_CYCLES);
      else n_pass++;
      e = sb.pop_front();
      n_checks++;
      if (observe(e.kind, e.idx) !== e.val)
        $display("FAIL write_store[%0d]: got %h, required %h", k, observe(e.kind, e.idx), e.val);
      else n_pass++;
    end
`ifdef K054539_READBACK_EN
    for (int k = 0; k < 3; k++) begin
      bus_access(1'b0, addrs[k], 8'h00, 7, p, w);
      n_checks++;
      if (PIN_DB_OUT !== datas[k])
        $display("FAIL readback[%0d]: got %h, required %h", k, PIN_DB_OUT, datas[k]);
      else n_pass++;
    end
`endif
  endtask

  task automatic test_keys();
    logic [9:0] addrs[3];
    logic [7:0] datas[3];
    int p, w;
    exp_t e;
    addrs = '{10'h214, 10'h215, 10'h22C};
    datas = '{8'hA5, 8'h05, 8'hFF};
    for (int k = 0; k < 3; k++) begin
      if (k == 0) m_status = m_status | datas[k];
      else if (k == 1) m_status = m_status & ~datas[k];
      e.kind = 2;
      e.idx = 0;
      e.val = m_status;
      sb.push_back(e);
      bus_access(1'b1, addrs[k], datas[k], 7, p, w);
      e = sb.pop_front();
      n_checks++;
      if (observe(e.kind, e.idx) !== e.val)
        $display("FAIL key_status[%0d]: got %h, required %h", k, observe(e.kind, e.idx), e.val);
      else n_pass++;
    end
    n_checks++;
    if (dut.ctrl_q[6'h14] !== 8'h00) $display("FAIL keyon_not_stored: got %h, required 00", dut.ctrl_q[6'h14]);
    else n_pass++;
`ifdef K054539_READBACK_EN
    bus_access(1'b0, 10'h22C, 8'h00, 7, p, w);
    n_checks++;
    if (PIN_DB_OUT !== 8'hA0) $display("FAIL status_read: got %h, required a0", PIN_DB_OUT); else n_pass++;
`endif
  endtask

  task automatic test_timebase();
    int last_dr, d_n, d_bad, d_hi, last_wr, w_per, w_hi, cnt_rise;
    bit pd, pw;
    last_dr = -1; d_n = 0; d_bad = 0; d_hi = -1;
    last_wr = -1; w_per = -1; w_hi = -1; cnt_rise = -1;
    @(negedge CLK);
    pd = PIN_DTCK;
    pw = PIN_WDCK;
    for (int i = 0; i < 800; i++) begin
      @(negedge CLK);
      if (PIN_DTCK && !pd) begin
        if (last_dr >= 0) begin
          d_n++;
          if (i - last_dr != 8) d_bad++;
        end
        last_dr = i;
      end
      if (!PIN_DTCK && pd && last_dr >= 0 && d_hi < 0) d_hi = i - last_dr;
      if (PIN_WDCK && !pw) begin
        if (last_wr >= 0) w_per = i - last_wr;
        else cnt_rise = int'(dut.cnt_q);
        last_wr = i;
      end
      if (!PIN_WDCK && pw && last_wr >= 0 && w_hi < 0) w_hi = i - last_wr;
      pd = PIN_DTCK;
      pw = PIN_WDCK;
    end
    n_checks++;
    if (d_n == 0 || d_bad != 0) $display("FAIL dtck_period: %0d of %0d periods not 8", d_bad, d_n); else n_pass++;
    n_checks++;
    if (d_hi != 4) $display("FAIL dtck_high: got %0d, required 4", d_hi); else n_pass++;
    n_checks++;
    if (w_per != 384) $display("FAIL wdck_period: got %0d, required 384", w_per); else n_pass++;
    n_checks++;
    if (w_hi != 192) $display("FAIL wdck_high: got %0d, required 192", w_hi); else n_pass++;
    n_checks++;
    if (cnt_rise != 192) $display("FAIL wdck_rise_cnt: got %0d, required 192", cnt_rise); else n_pass++;
  endtask

  task automatic test_single_access();
    int p, w;
    exp_t e;
    e.kind = 0;
    e.idx = 0;
    e.val = 8'h7E;
    sb.push_back(e);
    bus_access(1'b1, 10'h000, 8'h7E, 30, p, w);
    n_checks++;
    if (p !== 1 || w !== WAIT_CYCLES)
      $display("FAIL single_wait: pulses=%0d width=%0d, required 1 and %0d", p, w, WAIT_CYCLES);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if (observe(e.kind, e.idx) !== e.val)
      $display("FAIL single_store: got %h, required %h", observe(e.kind, e.idx), e.val);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    int guard, lows;
    guard = 0;
    lows = 0;
    @(negedge CLK);
    PIN_AB09 = 1'b0;
    PIN_AB = 8'h00;
    PIN_DB_IN = 8'h99;
    NCS = 1'b0;
    NWR = 1'b0;
    while (PIN_WAIT === 1'b1 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    n_checks++;
    if (PIN_WAIT !== 1'b0) $display("FAIL mid_wait_start: WAIT=%b after %0d clocks, required 0", PIN_WAIT, guard);
    else n_pass++;
    #2 NRES = 1'b0;
    #1;
    n_checks++;
    if (PIN_WAIT !== 1'b1) $display("FAIL mid_reset_wait: got %b, required 1", PIN_WAIT); else n_pass++;
    n_checks++;
    if (dut.status_q !== 8'h00) $display("FAIL mid_reset_status: got %h, required 00", dut.status_q); else n_pass++;
    PIN_DB_IN = 8'h33;
    repeat (3) @(negedge CLK);
    NRES = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (!PIN_WAIT) lows++;
    end
    n_checks++;
    if (lows != 0) $display("FAIL mid_no_new_wait: %0d WAIT-low clocks, required 0", lows); else n_pass++;
    n_checks++;
    if (dut.ram_q[8'h00] !== 8'h99) $display("FAIL mid_no_new_write: got %h, required 99", dut.ram_q[8'h00]);
    else n_pass++;
    NCS = 1'b1;
    NWR = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_writes();
    test_keys();
    test_timebase();
    test_single_access();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
